// File: rtl/fetch_pkg.sv
// Shared fetch types and helpers for the instruction prefetch path.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package fetch_pkg;

    localparam logic [1:0] RVC_OPC_MASK = 2'b11;

    typedef logic [31:0] fetch_word_t;

    // A halfword starts a compressed instruction unless both opcode LSBs are set.
    function automatic logic is_rvc(input logic [15:0] half);
        return (half[1:0] & RVC_OPC_MASK) != RVC_OPC_MASK;
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// DEPTH x 32 word FIFO exposing the head and the word behind it for realignment.
// Latency: a word pushed at edge N is visible on head/headNext in cycle N+1.
// Backpressure: none internally; the caller guarantees space before every push.
module prefetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  fetch_word_t                pushData,
    input  logic                       pop,
    output fetch_word_t                head,
    output fetch_word_t                headNext,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_word_t   mem [DEPTH];
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;

    // Pointers wrap naturally because DEPTH is a power of two.
    assign head     = mem[rdPtr];
    assign headNext = mem[rdPtr + PW'(1)];

    // Storage array; contents are don't-care until counted as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= pushData;
        end
    end

    // Pointer and occupancy tracking; clear drops everything in one cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/instr_prefetch_buf.sv
// Prefetches instruction words ahead of IF/ID and realigns RVC/32-bit instructions.
// Latency: a response stored at edge N can be presented as an instruction in cycle N+1.
// Backpressure: requests stop once buffered plus in-flight words reach DEPTH; instr_ready_i stalls output.
module instr_prefetch_buf
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic [ADDR_WIDTH-1:0] flush_pc_i,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
    input  logic                  mem_rsp_valid_i,
    input  logic [31:0]           mem_rsp_data_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [31:0]           instr_o,
    output logic [ADDR_WIDTH-1:0] instr_pc_o,
    output logic                  instr_16bit_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_WIDTH-1:0] fetchAddr;
    logic [ADDR_WIDTH-1:0] curPc;
    logic                  halfOff;
    logic [CW-1:0]         outstanding;
    logic [CW-1:0]         discardCnt;
    logic [CW-1:0]         fifoCount;
    logic [CW:0]           inFlight;
    fetch_word_t           headWord;
    fetch_word_t           nextWord;
    logic [15:0]           headHalf;
    logic                  headRvc;
    logic                  haveWords;
    logic                  reqFire;
    logic                  rspPush;
    logic                  instrFire;
    logic                  popWord;

    // Every word buffered or still in flight has a reserved FIFO slot.
    assign inFlight        = {1'b0, fifoCount} + {1'b0, outstanding};
    assign mem_req_valid_o = !rst && !flush_i && (inFlight < (CW + 1)'(DEPTH));
    assign mem_req_addr_o  = fetchAddr;
    assign reqFire         = mem_req_valid_o && mem_req_ready_i;

    // Responses to requests issued before a redirect are dropped, as are any in the flush cycle.
    assign rspPush = mem_rsp_valid_i && !rst && !flush_i && (discardCnt == '0);

    // Realignment: the head halfword decides whether one or two FIFO words are needed.
    assign headHalf      = halfOff ? headWord[31:16] : headWord[15:0];
    assign headRvc       = is_rvc(headHalf);
    assign haveWords     = (!headRvc && halfOff) ? (fifoCount >= CW'(2)) : (fifoCount != '0);
    assign instr_valid_o = !rst && !flush_i && haveWords;
    assign instrFire     = instr_valid_o && instr_ready_i;
    assign popWord       = instrFire && (!headRvc || halfOff);
    assign instr_16bit_o = instr_valid_o && headRvc;
    assign instr_pc_o    = curPc;

    // Instruction assembly; driven to zero whenever nothing valid is presented.
    always_comb begin
        instr_o = '0;
        if (instr_valid_o) begin
            if (headRvc) begin
                instr_o = {16'h0000, headHalf};
            end else if (halfOff) begin
                instr_o = {nextWord[15:0], headWord[31:16]};
            end else begin
                instr_o = headWord;
            end
        end
    end

    prefetch_fifo #(
        .DEPTH(DEPTH)
    ) fifoInst (
        .clk     (clk),
        .rst     (rst),
        .clear   (flush_i),
        .push    (rspPush),
        .pushData(mem_rsp_data_i),
        .pop     (popWord),
        .head    (headWord),
        .headNext(nextWord),
        .count   (fifoCount)
    );

    // In-flight request accounting; a redirect turns all in-flight responses into discards.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            discardCnt  <= '0;
        end else if (flush_i) begin
            outstanding <= outstanding - CW'(mem_rsp_valid_i);
            discardCnt  <= outstanding - CW'(mem_rsp_valid_i);
        end else begin
            outstanding <= outstanding + CW'(reqFire) - CW'(mem_rsp_valid_i);
            if (mem_rsp_valid_i && (discardCnt != '0)) begin
                discardCnt <= discardCnt - CW'(1);
            end
        end
    end

    // Fetch address and instruction PC tracking, reloaded on reset or redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetchAddr <= RESET_PC;
            curPc     <= RESET_PC;
            halfOff   <= 1'b0;
        end else if (flush_i) begin
            fetchAddr <= {flush_pc_i[ADDR_WIDTH-1:2], 2'b00};
            curPc     <= {flush_pc_i[ADDR_WIDTH-1:1], 1'b0};
            halfOff   <= flush_pc_i[1];
        end else begin
            if (reqFire) begin
                fetchAddr <= fetchAddr + ADDR_WIDTH'(4);
            end
            if (instrFire) begin
                curPc <= curPc + (headRvc ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4));
                if (headRvc) begin
                    halfOff <= !halfOff;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_prefetch_buf.sv
// Randomized bench: memory model with variable latency, scoreboard of expected instructions.
// Latency: not applicable.
// Backpressure: random memory-ready and IF/ID-ready, plus directed full-buffer stall.
module tb_instr_prefetch_buf;

    localparam int          AW       = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush_i;
    logic [AW-1:0] flush_pc_i;
    logic          mem_req_valid_o;
    logic          mem_req_ready_i;
    logic [AW-1:0] mem_req_addr_o;
    logic          mem_rsp_valid_i;
    logic [31:0]   mem_rsp_data_i;
    logic          instr_valid_o;
    logic          instr_ready_i;
    logic [31:0]   instr_o;
    logic [AW-1:0] instr_pc_o;
    logic          instr_16bit_o;

    always #5 clk = ~clk;

    instr_prefetch_buf #(
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush_i),
        .flush_pc_i     (flush_pc_i),
        .mem_req_valid_o(mem_req_valid_o),
        .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o (mem_req_addr_o),
        .mem_rsp_valid_i(mem_rsp_valid_i),
        .mem_rsp_data_i (mem_rsp_data_i),
        .instr_valid_o  (instr_valid_o),
        .instr_ready_i  (instr_ready_i),
        .instr_o        (instr_o),
        .instr_pc_o     (instr_pc_o),
        .instr_16bit_o  (instr_16bit_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        is16;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    int          nChecks    = 0;
    int          nFails     = 0;
    int          cyc        = 0;
    int          lastDue    = 0;
    int          reqCount   = 0;
    int          handshakes = 0;
    logic        prevRst    = 1'b0;
    logic [31:0] imem [256];
    exp_t        expQ [$];
    pend_t       pendQ [$];
    logic [31:0] genPc;
    logic [31:0] expFetch;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] halfAt(input logic [31:0] a);
        logic [31:0] w;
        w = imem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Program-order decode of the instruction image from genPc onward.
    task automatic extendExp();
        logic [15:0] h;
        exp_t        e;
        while (expQ.size() < 64) begin
            h    = halfAt(genPc);
            e.pc = genPc;
            if (h[1:0] != 2'b11) begin
                e.instr = {16'h0000, h};
                e.is16  = 1'b1;
                genPc   = genPc + 2;
            end else begin
                e.instr = {halfAt(genPc + 2), h};
                e.is16  = 1'b0;
                genPc   = genPc + 4;
            end
            expQ.push_back(e);
        end
    endtask

    task automatic redirect(input logic [31:0] target);
        expQ.delete();
        genPc    = {target[31:1], 1'b0};
        expFetch = {target[31:2], 2'b00};
        extendExp();
    endtask

    // One clock of stimulus: memory responses, random knobs, request bookkeeping.
    task automatic step(input int flushPm, input int irdyPct, input int mrdyPct,
                        input int maxLat, input logic doRst);
        int    due;
        pend_t p;
        @(negedge clk);
        cyc++;
        rst             = doRst;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = $urandom;
        if (doRst) begin
            pendQ.delete();
            lastDue = cyc;
        end else if (pendQ.size() > 0 && pendQ[0].due == cyc) begin
            p               = pendQ.pop_front();
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = imem[p.addr[9:2]];
        end
        flush_i         = !doRst && ($urandom_range(999) < flushPm);
        flush_pc_i      = $urandom & 32'h0000_03FF;
        mem_req_ready_i = $urandom_range(99) < mrdyPct;
        instr_ready_i   = $urandom_range(99) < irdyPct;
        #1;
        if (doRst) begin
            if (prevRst) begin
                check("rst_req_valid", {31'd0, mem_req_valid_o}, 32'd0);
                check("rst_instr_valid", {31'd0, instr_valid_o}, 32'd0);
                check("rst_req_addr", mem_req_addr_o, RESET_PC);
                check("rst_instr_pc", instr_pc_o, RESET_PC);
                check("rst_instr", instr_o, 32'd0);
                check("rst_instr_16bit", {31'd0, instr_16bit_o}, 32'd0);
            end
            redirect(RESET_PC);
        end else if (flush_i) begin
            check("flush_req_valid", {31'd0, mem_req_valid_o}, 32'd0);
            check("flush_instr_valid", {31'd0, instr_valid_o}, 32'd0);
            redirect(flush_pc_i);
        end else if (mem_req_valid_o && mem_req_ready_i) begin
            check("req_addr", mem_req_addr_o, expFetch);
            expFetch = expFetch + 4;
            reqCount++;
            due = cyc + int'($urandom_range(maxLat, 1));
            if (due <= lastDue) due = lastDue + 1;
            lastDue = due;
            p.addr  = mem_req_addr_o;
            p.due   = due;
            pendQ.push_back(p);
        end
        nChecks++;
        if (dut.fifoCount > DEPTH) begin
            nFails++;
            $display("FAIL fifo_overflow: count %0d exceeds %0d (cycle %0d)", dut.fifoCount, DEPTH, cyc);
        end
        prevRst = doRst;
    endtask

    // Monitor: every instruction handshake is checked against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (instr_valid_o && instr_ready_i) begin
                handshakes++;
                if (expQ.size() == 0) begin
                    nChecks++;
                    nFails++;
                    $display("FAIL unexpected_instr: pc 0x%08h with empty scoreboard", instr_pc_o);
                end else begin
                    e = expQ.pop_front();
                    check("instr_pc", instr_pc_o, e.pc);
                    check("instr", instr_o, e.instr);
                    check("instr_16bit", {31'd0, instr_16bit_o}, {31'd0, e.is16});
                    extendExp();
                end
            end
        end
    end

    initial begin
        logic [15:0] h;
        rst             = 1'b1;
        flush_i         = 1'b0;
        flush_pc_i      = '0;
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_data_i  = '0;
        instr_ready_i   = 1'b0;

        // Random image with roughly half 32-bit opcodes, plus directed words at the start.
        for (int i = 0; i < 256; i++) begin
            for (int k = 0; k < 2; k++) begin
                h = 16'($urandom);
                if ($urandom_range(1) == 1) h[1:0] = 2'b11;
                if (k == 0) imem[i][15:0] = h;
                else imem[i][31:16] = h;
            end
        end
        imem[0] = 32'h0005_4501;
        imem[1] = 32'h0000_0013;
        imem[2] = 32'h0093_4501;
        imem[3] = 32'h0000_0050;
        imem[4] = 32'h0050_0093;
        imem[5] = 32'h00A0_0113;

        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1'b1);

        // Stalled IF/ID with single-cycle memory: exactly DEPTH requests are accepted.
        reqCount = 0;
        for (int i = 0; i < 12; i++) step(0, 0, 100, 1, 1'b0);
        check("stall_req_count", reqCount, DEPTH);
        check("stall_req_valid", {31'd0, mem_req_valid_o}, 32'd0);

        for (int i = 0; i < 40; i++) step(0, 100, 100, 1, 1'b0);
        for (int i = 0; i < 3000; i++) step(20, 70, 70, 3, 1'b0);

        // Reset in the middle of traffic.
        step(0, 100, 100, 1, 1'b1);
        step(0, 100, 100, 1, 1'b1);

        for (int i = 0; i < 2000; i++) step(50, 90, 90, 1, 1'b0);
        for (int i = 0; i < 2000; i++) step(10, 40, 50, 3, 1'b0);
        step(0, 0, 0, 1, 1'b0);
        #5;
        check("handshake_progress", {31'd0, handshakes > 500}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
